// File: rtl/z_velocity_estimator_pkg.sv
// Shared constants and types for the z-axis velocity estimator: state encoding,
// rate multiplier width and default tuning values.
package z_velocity_estimator_pkg;

   // A SCALE below 2^10 fits in a signed 11-bit multiplier operand.
   localparam int RATE_BIT_WIDTH = 11;

   localparam int ZVE_NUM_STATES = 7;
   localparam logic [ZVE_NUM_STATES-1:0] ST_INIT  = 7'b000_0001;
   localparam logic [ZVE_NUM_STATES-1:0] ST_WAIT  = 7'b000_0010;
   localparam logic [ZVE_NUM_STATES-1:0] ST_LATCH = 7'b000_0100;
   localparam logic [ZVE_NUM_STATES-1:0] ST_CHECK = 7'b000_1000;
   localparam logic [ZVE_NUM_STATES-1:0] ST_CALC  = 7'b001_0000;
   localparam logic [ZVE_NUM_STATES-1:0] ST_SAT   = 7'b010_0000;
   localparam logic [ZVE_NUM_STATES-1:0] ST_WRITE = 7'b100_0000;

   localparam int ZVE_DEFAULT_SCALE    = 50;
   localparam int ZVE_DEFAULT_DEPTH    = 4;
   localparam int ZVE_DEFAULT_MAX_STEP = 200;

   typedef enum logic [1:0] {
      OUTC_ACCEPT = 2'd0,
      OUTC_REJECT = 2'd1,
      OUTC_RESEED = 2'd2
   } zve_outcome_e;

endpackage

// File: rtl/z_velocity_estimator_ring.sv
// Altitude history ring: DEPTH registers with a wrapping write pointer,
// single-entry write, broadcast seed, and oldest/newest read taps.
module altitude_history_ring #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  us_clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  seed_en,
   input  logic [DATA_WIDTH-1:0] seed_data,
   output logic [DATA_WIDTH-1:0] oldest,
   output logic [DATA_WIDTH-1:0] newest
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] hist;
   logic [PTR_W-1:0]                 wr_ptr;

   // DEPTH is a power of two, so the pointer wraps by natural overflow.
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         hist   <= '0;
         wr_ptr <= '0;
      end else if (seed_en) begin
         hist   <= {DEPTH{seed_data}};
         wr_ptr <= '0;
      end else if (wr_en) begin
         hist[wr_ptr] <= wr_data;
         wr_ptr       <= wr_ptr + PTR_W'(1);
      end
   end

   assign oldest = hist[wr_ptr];
   assign newest = hist[wr_ptr - PTR_W'(1)];

endmodule

// File: rtl/z_velocity_estimator.sv
// Windowed z-axis velocity: (oldest - newest) * SCALE / DEPTH, saturated, with
// single-sample glitch rejection and automatic re-seed of the history.
module z_velocity_estimator
   import z_velocity_estimator_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 16,
   parameter int DEPTH      = ZVE_DEFAULT_DEPTH,
   parameter int SCALE      = ZVE_DEFAULT_SCALE,
   parameter int MAX_STEP   = ZVE_DEFAULT_MAX_STEP,
   parameter int MAX_REJECT = 3
) (
   input  logic                         us_clk,
   input  logic                         reset,
   input  logic                         start_signal,
   input  logic signed [DATA_WIDTH-1:0] z_altitude_mm,
   output logic signed [OUT_WIDTH-1:0]  z_linear_velocity,
   output logic                         velocity_valid,
   output logic                         sample_rejected,
   output logic                         primed,
   output logic                         busy
);

   localparam int DW1   = DATA_WIDTH + 1;
   localparam int PW    = DW1 + RATE_BIT_WIDTH;
   localparam int SHIFT = $clog2(DEPTH);
   localparam int ACC_W = $clog2(DEPTH + 1);
   localparam int RC_W  = $clog2(MAX_REJECT + 1);

   localparam logic        [DW1-1:0]   MAX_STEP_W = DW1'(MAX_STEP);
   localparam logic        [RC_W-1:0]  MAX_REJ_W  = RC_W'(MAX_REJECT);
   localparam logic        [ACC_W-1:0] ACC_FULL   = ACC_W'(DEPTH);
   localparam logic        [ACC_W-1:0] ACC_LAST   = ACC_W'(DEPTH - 1);
   localparam logic signed [PW-1:0]    SCALE_S    = PW'(SCALE);
   localparam logic signed [PW-1:0]    OUT_MAX    = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0]    OUT_MIN    = {{(PW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic [ZVE_NUM_STATES-1:0] state, next_state;

   logic signed [DATA_WIDTH-1:0] latched;
   logic        [DATA_WIDTH-1:0] oldest, newest;
   zve_outcome_e                 outcome;
   logic signed [PW-1:0]         calc_q;
   logic signed [OUT_WIDTH-1:0]  sat_q;
   logic                         seeded;
   logic        [ACC_W-1:0]      accept_cnt;
   logic        [RC_W-1:0]       reject_cnt;

   logic signed [DW1-1:0] step, diff;
   logic        [DW1-1:0] step_abs;
   logic                  step_big;
   logic signed [PW-1:0]  diff_ext, prod, scaled;

   altitude_history_ring #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ring (
      .us_clk    (us_clk),
      .reset     (reset),
      .wr_en     (state == ST_WRITE && outcome == OUTC_ACCEPT),
      .wr_data   (latched),
      .seed_en   (state == ST_WRITE && outcome == OUTC_RESEED),
      .seed_data (latched),
      .oldest    (oldest),
      .newest    (newest)
   );

   always_comb begin
      next_state = state;
      case (state)
         ST_INIT:  next_state = ST_WAIT;
         ST_WAIT:  if (start_signal) next_state = ST_LATCH;
         ST_LATCH: next_state = ST_CHECK;
         ST_CHECK: next_state = ST_CALC;
         ST_CALC:  next_state = ST_SAT;
         ST_SAT:   next_state = ST_WRITE;
         ST_WRITE: next_state = ST_WAIT;
         default:  next_state = ST_INIT;
      endcase
   end

   // Step against the newest sample drives glitch detection; the full-window
   // difference (older minus newer) drives the velocity.
   assign step     = {latched[DATA_WIDTH-1], latched} - {newest[DATA_WIDTH-1], newest};
   assign step_abs = step[DW1-1] ? DW1'(-step) : step;
   assign step_big = (MAX_STEP != 0) && (step_abs > MAX_STEP_W);
   assign diff     = {oldest[DATA_WIDTH-1], oldest} - {latched[DATA_WIDTH-1], latched};
   assign diff_ext = {{RATE_BIT_WIDTH{diff[DW1-1]}}, diff};
   assign prod     = diff_ext * SCALE_S;
   assign scaled   = prod >>> SHIFT;

   assign busy = (state != ST_WAIT);

   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         state             <= ST_INIT;
         latched           <= '0;
         outcome           <= OUTC_ACCEPT;
         calc_q            <= '0;
         sat_q             <= '0;
         seeded            <= 1'b0;
         accept_cnt        <= '0;
         reject_cnt        <= '0;
         z_linear_velocity <= '0;
         velocity_valid    <= 1'b0;
         sample_rejected   <= 1'b0;
         primed            <= 1'b0;
      end else begin
         state           <= next_state;
         velocity_valid  <= 1'b0;
         sample_rejected <= 1'b0;
         case (state)
            ST_LATCH: latched <= z_altitude_mm;
            ST_CHECK: begin
               if (!seeded)                               outcome <= OUTC_RESEED;
               else if (step_big && reject_cnt < MAX_REJ_W) outcome <= OUTC_REJECT;
               else if (step_big)                         outcome <= OUTC_RESEED;
               else                                       outcome <= OUTC_ACCEPT;
            end
            ST_CALC: calc_q <= scaled;
            ST_SAT: begin
               if (calc_q > OUT_MAX)      sat_q <= OUT_MAX[OUT_WIDTH-1:0];
               else if (calc_q < OUT_MIN) sat_q <= OUT_MIN[OUT_WIDTH-1:0];
               else                       sat_q <= calc_q[OUT_WIDTH-1:0];
            end
            ST_WRITE: begin
               velocity_valid <= 1'b1;
               case (outcome)
                  OUTC_ACCEPT: begin
                     reject_cnt        <= '0;
                     z_linear_velocity <= sat_q;
                     if (accept_cnt != ACC_FULL) accept_cnt <= accept_cnt + ACC_W'(1);
                     if (accept_cnt >= ACC_LAST) primed <= 1'b1;
                  end
                  OUTC_REJECT: begin
                     reject_cnt      <= reject_cnt + RC_W'(1);
                     sample_rejected <= 1'b1;
                  end
                  default: begin
                     seeded            <= 1'b1;
                     accept_cnt        <= '0;
                     reject_cnt        <= '0;
                     primed            <= 1'b0;
                     z_linear_velocity <= '0;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
